vmem1_map_ctl: RTL and testbench
================================

Name: vmem1_map_ctl

Overview:
- Initiator-side controller for the 1Kx24 level-1 virtual-memory map RAM.
- Drives RAM port A only: address, write data, write enable, read enable. Consumes registered read data q_a.
- On reset, clears all 1024 map entries to zero.
- After clearing, it serves pipelined CPU map lookups and a host/debug read-write port with a req/ack handshake. Priority and anti-starvation arbitration decide which requester uses the RAM each cycle.

Parameters:
- AW, 10, map address width; depth = 2**AW.
- DW, 24, map entry width.
- HOST_MAX_WAIT, 8, cycles host_req may wait before host gains priority over the CPU.

Ports:
- clk_a  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- cpu_rd_req  in  1  CPU lookup request; accepted in any cycle where cpu_rd_ready=1.
- cpu_addr  in  AW  CPU lookup address.
- cpu_rd_ready  out  1  controller accepts a CPU lookup this cycle.
- cpu_rd_valid  out  1  one-cycle pulse; cpu_rd_data is valid.
- cpu_rd_data  out  DW  lookup result.
- host_req  in  1  level request; held with its fields stable until host_ack.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DW  read data; valid with host_ack on reads.
- init_done  out  1  clear sequence complete.
- ram_addr  out  AW  to RAM address_a.
- ram_wdata  out  DW  to RAM data_a.
- ram_wren  out  1  to RAM wren_a.
- ram_rden  out  1  to RAM rden_a.
- ram_q  in  DW  from RAM q_a; registered, valid the cycle after ram_rden.

Behaviour:
- Reset values: every output 0. Internal state also clears: clear counter=0, wait counter=0, pipeline valids=0, state=CLEAR.
- All RAM outputs are registered.
- FSM states: CLEAR and RUN.
- CLEAR state:
  - Issues one write per cycle: ram_wren=1, ram_wdata=0, ram_addr=counter, counter increments.
  - After the address 2**AW-1 write is issued, goes to RUN and sets init_done=1 in that same cycle.
  - The clear takes exactly 1024 cycles.
  - cpu_rd_ready=0 and host_req is ignored throughout CLEAR.
- RUN arbitration, evaluated every cycle:
  - The host gets the RAM in a cycle when host_req=1, no host operation is in flight, and either wait count ≥ HOST_MAX_WAIT or cpu_rd_req=0.
  - Otherwise the CPU gets the RAM.
  - cpu_rd_ready = RUN & ~(host granted this cycle).
- Wait counter: increments while host_req=1 and the host is not granted; clears on grant. It saturates at HOST_MAX_WAIT.
- CPU lookup timing:
  - Accepted at cycle N.
  - Cycle N+1: ram_rden=1, ram_addr=cpu_addr.
  - Cycle N+2: cpu_rd_valid=1, cpu_rd_data=ram_q.
  - Latency is exactly 2. Throughput is 1 per cycle; back-to-back lookups return in order.
- Host write granted at N: cycle N+1 has ram_wren=1 and host_ack=1.
- Host read granted at N: ram_rden at N+1; host_ack=1 and host_rdata=ram_q at N+2.
- Host in-flight rule: at most one host operation in flight. The host is not re-granted until the cycle after host_ack.
- Return path: a 2-stage tag pipeline (valid plus source bit) routes each ram_q to the CPU or the host. cpu_rd_data and host_rdata hold their last value between pulses.
- ram_rden and ram_wren are never both 1 in the same cycle. Idle cycles drive both to 0.
- Read-after-write to the same address in consecutive cycles returns the new data. No bypass is needed, because the write lands at the edge before the read samples.
- Reset mid-operation: the next cycle restarts CLEAR from address 0 and drops in-flight reads (no valid or ack pulse). init_done goes to 0.
- Address wrap: the clear counter is AW+1 bits; bit AW set marks CLEAR complete. No other counter wraps.

Decomposition:
- Shared package: AW/DW defaults, CLEAR/RUN state encoding, and the source-tag encoding (TAG_CPU=0, TAG_HOST=1).
- One natural sub-module, vmem1_rd_tagpipe: the 2-stage valid+tag pipeline that steers ram_q to the CPU or host outputs.
- Arbitration, the FSM and counters stay in the top module.

Test Plan:
- Reset, then run: ram_wren high for exactly 1024 consecutive cycles with ram_addr 0..1023 and ram_wdata=0. init_done rises in the cycle after the last write. A CPU lookup of 0o1777 then returns 0.
- Host write 0o123 <- 24'o7654321, then CPU lookup 0o123: host_ack one cycle after grant; cpu_rd_valid two cycles after acceptance with data 24'o7654321.
- CPU issues lookups to addresses 1,2,3,4 on four consecutive cycles (entries preloaded 10..13): four consecutive cpu_rd_valid pulses, data 10,11,12,13 in order, no bubbles.
- CPU asserts cpu_rd_req continuously while host_req (read of 0o5) is held: cpu_rd_ready drops after exactly HOST_MAX_WAIT=8 wait cycles, the host read is granted, and host_ack with the correct data follows 2 cycles later.
- Host write 0o7 <- 24'h00ABCD immediately followed by a CPU read of 0o7: the CPU read returns 24'h00ABCD.
- Reset asserted one cycle after a CPU lookup is accepted: no cpu_rd_valid pulse, init_done=0, and CLEAR restarts at address 0.

Source files
------------

// File: rtl/vmem1_map_ctl_pkg.sv
// Shared definitions for the level-1 virtual-memory map controller.
package vmem1_map_ctl_pkg;

    localparam int unsigned VMEM1_AW = 10;
    localparam int unsigned VMEM1_DW = 24;

    // Controller state encoding
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Source tag carried alongside each RAM read
    localparam logic TAG_CPU  = 1'b0;
    localparam logic TAG_HOST = 1'b1;

    typedef struct packed {
        logic vld;
        logic tag;
    } rd_tag_t;

endpackage

// File: rtl/vmem1_rd_tagpipe.sv
// Two-stage valid+tag pipeline that steers registered RAM read data to the
// CPU or host return port. Stage 2 lines up with q_a of the RAM.
module vmem1_rd_tagpipe
    import vmem1_map_ctl_pkg::*;
#(
    parameter int unsigned DW = VMEM1_DW
) (
    input  logic          clk_a,
    input  logic          reset,
    input  logic          i_issue,
    input  logic          i_tag,
    input  logic [DW-1:0] i_ram_q,
    output logic          o_cpu_valid,
    output logic [DW-1:0] o_cpu_data,
    output logic          o_host_valid,
    output logic [DW-1:0] o_host_data
);

    rd_tag_t       r_s1;
    rd_tag_t       r_s2;
    logic [DW-1:0] r_cpu_hold;
    logic [DW-1:0] r_host_hold;
    logic          w_cpu_hit;
    logic          w_host_hit;

    assign w_cpu_hit  = r_s2.vld & (r_s2.tag == TAG_CPU);
    assign w_host_hit = r_s2.vld & (r_s2.tag == TAG_HOST);

    // Advance the tag pipeline; latch returned data so outputs hold between pulses
    always_ff @(posedge clk_a) begin
        if (reset) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_cpu_hold  <= '0;
            r_host_hold <= '0;
        end else begin
            r_s1 <= '{vld: i_issue, tag: i_tag};
            r_s2 <= r_s1;
            if (w_cpu_hit) begin
                r_cpu_hold <= i_ram_q;
            end
            if (w_host_hit) begin
                r_host_hold <= i_ram_q;
            end
        end
    end

    assign o_cpu_valid  = w_cpu_hit;
    assign o_cpu_data   = w_cpu_hit ? i_ram_q : r_cpu_hold;
    assign o_host_valid = w_host_hit;
    assign o_host_data  = w_host_hit ? i_ram_q : r_host_hold;

endmodule

// File: rtl/vmem1_map_ctl.sv
// Port-A initiator for the 1Kx24 level-1 map RAM: clears the map after reset,
// then arbitrates between pipelined CPU lookups and a req/ack host port.
module vmem1_map_ctl
    import vmem1_map_ctl_pkg::*;
#(
    parameter int unsigned AW            = VMEM1_AW,
    parameter int unsigned DW            = VMEM1_DW,
    parameter int unsigned HOST_MAX_WAIT = 8
) (
    input  logic          clk_a,
    input  logic          reset,
    input  logic          i_cpu_rd_req,
    input  logic [AW-1:0] i_cpu_addr,
    output logic          o_cpu_rd_ready,
    output logic          o_cpu_rd_valid,
    output logic [DW-1:0] o_cpu_rd_data,
    input  logic          i_host_req,
    input  logic          i_host_we,
    input  logic [AW-1:0] i_host_addr,
    input  logic [DW-1:0] i_host_wdata,
    output logic          o_host_ack,
    output logic [DW-1:0] o_host_rdata,
    output logic          o_init_done,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_wdata,
    output logic          o_ram_wren,
    output logic          o_ram_rden,
    input  logic [DW-1:0] i_ram_q
);

    localparam int unsigned WW = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(HOST_MAX_WAIT);

    logic [0:0]    r_state;
    logic [AW:0]   r_clr_cnt;
    logic [WW-1:0] r_wait;
    logic          r_host_busy;
    logic          r_host_wr_ack;
    logic          r_init_done;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wdata;
    logic          r_ram_wren;
    logic          r_ram_rden;

    logic          w_run;
    logic          w_host_grant;
    logic          w_cpu_acc;
    logic          w_rd_issue;
    logic          w_rd_tag;
    logic          w_host_rd_ack;

    // Arbitration: host wins when it has waited long enough or the CPU is idle
    always_comb begin
        w_run        = (r_state == ST_RUN) & ~reset;
        w_host_grant = w_run & i_host_req & ~r_host_busy &
                       ((r_wait >= WAIT_MAX) | ~i_cpu_rd_req);
        w_cpu_acc    = w_run & ~w_host_grant & i_cpu_rd_req;
        w_rd_issue   = w_cpu_acc | (w_host_grant & ~i_host_we);
        w_rd_tag     = w_host_grant ? TAG_HOST : TAG_CPU;
    end

    // FSM, clear sequencing and registered RAM port drive
    always_ff @(posedge clk_a) begin
        if (reset) begin
            r_state       <= ST_CLEAR;
            r_clr_cnt     <= '0;
            r_init_done   <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wdata   <= '0;
            r_ram_wren    <= 1'b0;
            r_ram_rden    <= 1'b0;
            r_host_wr_ack <= 1'b0;
        end else begin
            r_ram_wren    <= 1'b0;
            r_ram_rden    <= 1'b0;
            r_host_wr_ack <= 1'b0;
            if (r_state == ST_CLEAR) begin
                // Top counter bit set means every entry has been written
                if (r_clr_cnt[AW]) begin
                    r_state     <= ST_RUN;
                    r_init_done <= 1'b1;
                end else begin
                    r_ram_wren  <= 1'b1;
                    r_ram_addr  <= r_clr_cnt[AW-1:0];
                    r_ram_wdata <= '0;
                    r_clr_cnt   <= r_clr_cnt + 1'b1;
                end
            end else begin
                if (w_host_grant) begin
                    r_ram_addr <= i_host_addr;
                    if (i_host_we) begin
                        r_ram_wren    <= 1'b1;
                        r_ram_wdata   <= i_host_wdata;
                        r_host_wr_ack <= 1'b1;
                    end else begin
                        r_ram_rden <= 1'b1;
                    end
                end else if (w_cpu_acc) begin
                    r_ram_rden <= 1'b1;
                    r_ram_addr <= i_cpu_addr;
                end
            end
        end
    end

    // Host in-flight flag and anti-starvation wait counter
    always_ff @(posedge clk_a) begin
        if (reset) begin
            r_host_busy <= 1'b0;
            r_wait      <= '0;
        end else begin
            if (w_host_grant) begin
                r_host_busy <= 1'b1;
            end else if (o_host_ack) begin
                r_host_busy <= 1'b0;
            end
            // Only count cycles where the host is genuinely eligible but loses
            if (w_host_grant) begin
                r_wait <= '0;
            end else if (w_run && i_host_req && !r_host_busy && (r_wait < WAIT_MAX)) begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    vmem1_rd_tagpipe #(
        .DW (DW)
    ) u_tagpipe (
        .clk_a        (clk_a),
        .reset        (reset),
        .i_issue      (w_rd_issue),
        .i_tag        (w_rd_tag),
        .i_ram_q      (i_ram_q),
        .o_cpu_valid  (o_cpu_rd_valid),
        .o_cpu_data   (o_cpu_rd_data),
        .o_host_valid (w_host_rd_ack),
        .o_host_data  (o_host_rdata)
    );

    assign o_cpu_rd_ready = w_run & ~w_host_grant;
    assign o_host_ack     = r_host_wr_ack | w_host_rd_ack;
    assign o_init_done    = r_init_done;
    assign o_ram_addr     = r_ram_addr;
    assign o_ram_wdata    = r_ram_wdata;
    assign o_ram_wren     = r_ram_wren;
    assign o_ram_rden     = r_ram_rden;

endmodule

// File: tb/tb_vmem1_map_ctl.sv
// Scoreboard bench for vmem1_map_ctl with a behavioural 1Kx24 RAM on port A.
module tb_vmem1_map_ctl;

    typedef struct {
        logic [23:0] data;
        int          cyc;
        bit          chk_data;
    } exp_t;

    logic        clk_a;
    logic        reset;
    logic        cpu_rd_req;
    logic [9:0]  cpu_addr;
    logic        cpu_rd_ready;
    logic        cpu_rd_valid;
    logic [23:0] cpu_rd_data;
    logic        host_req;
    logic        host_we;
    logic [9:0]  host_addr;
    logic [23:0] host_wdata;
    logic        host_ack;
    logic [23:0] host_rdata;
    logic        init_done;
    logic [9:0]  ram_addr;
    logic [23:0] ram_wdata;
    logic        ram_wren;
    logic        ram_rden;
    logic [23:0] ram_q;

    logic [23:0] mem [1024];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    int          overlap = 0;
    exp_t        q_cpu[$];
    exp_t        q_host[$];

    vmem1_map_ctl #(
        .AW            (10),
        .DW            (24),
        .HOST_MAX_WAIT (8)
    ) dut (
        .clk_a          (clk_a),
        .reset          (reset),
        .i_cpu_rd_req   (cpu_rd_req),
        .i_cpu_addr     (cpu_addr),
        .o_cpu_rd_ready (cpu_rd_ready),
        .o_cpu_rd_valid (cpu_rd_valid),
        .o_cpu_rd_data  (cpu_rd_data),
        .i_host_req     (host_req),
        .i_host_we      (host_we),
        .i_host_addr    (host_addr),
        .i_host_wdata   (host_wdata),
        .o_host_ack     (host_ack),
        .o_host_rdata   (host_rdata),
        .o_init_done    (init_done),
        .o_ram_addr     (ram_addr),
        .o_ram_wdata    (ram_wdata),
        .o_ram_wren     (ram_wren),
        .o_ram_rden     (ram_rden),
        .i_ram_q        (ram_q)
    );

    initial clk_a = 1'b0;
    always #5 clk_a = ~clk_a;

    // Behavioural RAM: registered q_a, valid the cycle after rden
    always @(posedge clk_a) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        if (ram_rden) ram_q <= mem[ram_addr];
    end

    always @(posedge clk_a) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pop the scoreboard whenever the DUT presents a response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_a);
            if (ram_wren && ram_rden) overlap++;
            if (cpu_rd_valid) begin
                if (q_cpu.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL cpu_unexpected_valid: got data %0h expected no pulse (cycle %0d)",
                             cpu_rd_data, cyc);
                end else begin
                    e = q_cpu.pop_front();
                    chk("cpu_data", 64'(cpu_rd_data), 64'(e.data));
                    chk("cpu_latency", 64'(cyc), 64'(e.cyc));
                end
            end
            if (host_ack) begin
                if (q_host.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL host_unexpected_ack: got ack expected no pulse (cycle %0d)", cyc);
                end else begin
                    e = q_host.pop_front();
                    if (e.chk_data) chk("host_rdata", 64'(host_rdata), 64'(e.data));
                    chk("host_ack_latency", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic push_cpu(input logic [23:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc = c;
        e.chk_data = 1'b1;
        q_cpu.push_back(e);
    endtask

    task automatic push_host(input logic [23:0] d, input int c, input bit cd);
        exp_t e;
        e.data = d;
        e.cyc = c;
        e.chk_data = cd;
        q_host.push_back(e);
    endtask

    // Entered and left just after a rising edge
    task automatic cpu_lookup(input logic [9:0] a, input logic [23:0] exp_d);
        bit got = 1'b0;
        cpu_rd_req = 1'b1;
        cpu_addr = a;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_a);
            if (cpu_rd_ready) begin
                got = 1'b1;
                push_cpu(exp_d, cyc + 2);
            end
            @(posedge clk_a);
            #1;
        end
        cpu_rd_req = 1'b0;
        chk("cpu_accept_timeout", 64'(got), 64'd1);
    endtask

    task automatic host_op(input bit we, input logic [9:0] a, input logic [23:0] wd,
                           input logic [23:0] exp_rd);
        bit got = 1'b0;
        bit acked = 1'b0;
        host_req = 1'b1;
        host_we = we;
        host_addr = a;
        host_wdata = wd;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_a);
            if (!cpu_rd_ready) begin
                got = 1'b1;
                push_host(exp_rd, we ? cyc + 1 : cyc + 2, !we);
            end else begin
                @(posedge clk_a);
                #1;
            end
        end
        chk("host_grant_timeout", 64'(got), 64'd1);
        for (int i = 0; i < 10 && got && !acked; i++) begin
            @(negedge clk_a);
            acked = host_ack;
        end
        @(posedge clk_a);
        #1;
        host_req = 1'b0;
        if (got) chk("host_ack_timeout", 64'(acked), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q_cpu.size() + q_host.size()) != 0; i++) begin
            @(posedge clk_a);
            #1;
        end
        chk("drain", 64'(q_cpu.size() + q_host.size()), 64'd0);
    endtask

    initial begin
        int  bad;
        int  nready;
        bit  granted;
        bit  acked;

        reset = 1'b1;
        cpu_rd_req = 1'b0;
        cpu_addr = '0;
        host_req = 1'b0;
        host_we = 1'b0;
        host_addr = '0;
        host_wdata = '0;
        repeat (3) @(posedge clk_a);
        @(negedge clk_a);
        chk("reset_outputs", 64'({cpu_rd_ready, cpu_rd_valid, cpu_rd_data, host_ack, init_done}),
            64'd0);
        chk("reset_ram_port", 64'({host_rdata, ram_wren, ram_rden, ram_addr}), 64'd0);
        @(posedge clk_a);
        #1;
        reset = 1'b0;

        // Clear sequence: 1024 consecutive zero writes, then init_done
        @(negedge clk_a);
        chk("clear_not_started", 64'(ram_wren), 64'd0);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk_a);
            if (!(ram_wren === 1'b1 && ram_rden === 1'b0 && ram_addr === 10'(i) &&
                  ram_wdata === 24'd0 && init_done === 1'b0 && cpu_rd_ready === 1'b0)) bad++;
        end
        chk("clear_seq_bad_cycles", 64'(bad), 64'd0);
        @(negedge clk_a);
        chk("init_done_after_clear", 64'(init_done), 64'd1);
        chk("wren_off_after_clear", 64'(ram_wren), 64'd0);
        @(posedge clk_a);
        #1;

        cpu_lookup(10'o1777, 24'd0);
        drain();

        // Host write then CPU lookup of the same entry
        host_op(1'b1, 10'o123, 24'o7654321, 24'd0);
        cpu_lookup(10'o123, 24'o7654321);
        drain();

        // Preload 1..4 and stream four back-to-back lookups
        for (int k = 0; k < 4; k++) host_op(1'b1, 10'(k + 1), 24'(10 + k), 24'd0);
        drain();
        cpu_rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cpu_addr = 10'(k + 1);
            @(negedge clk_a);
            chk("b2b_ready", 64'(cpu_rd_ready), 64'd1);
            push_cpu(24'(10 + k), cyc + 2);
            @(posedge clk_a);
            #1;
        end
        cpu_rd_req = 1'b0;
        drain();

        // Anti-starvation: host read of 0o5 against a continuous CPU stream
        host_op(1'b1, 10'o5, 24'h5A5A5A, 24'd0);
        drain();
        cpu_rd_req = 1'b1;
        cpu_addr = 10'd1;
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = 10'o5;
        nready = 0;
        granted = 1'b0;
        for (int i = 0; i < 30 && !granted; i++) begin
            @(negedge clk_a);
            if (cpu_rd_ready) begin
                nready++;
                push_cpu(24'd10, cyc + 2);
            end else begin
                granted = 1'b1;
                push_host(24'h5A5A5A, cyc + 2, 1'b1);
            end
            @(posedge clk_a);
            #1;
        end
        cpu_rd_req = 1'b0;
        chk("starve_granted", 64'(granted), 64'd1);
        chk("starve_wait_cycles", 64'(nready), 64'd8);
        acked = 1'b0;
        for (int i = 0; i < 10 && !acked; i++) begin
            @(negedge clk_a);
            acked = host_ack;
            @(posedge clk_a);
            #1;
        end
        host_req = 1'b0;
        chk("starve_ack_seen", 64'(acked), 64'd1);
        drain();

        // Host write 0o7 immediately followed by a CPU read of 0o7
        host_req = 1'b1;
        host_we = 1'b1;
        host_addr = 10'o7;
        host_wdata = 24'h00ABCD;
        granted = 1'b0;
        for (int i = 0; i < 10 && !granted; i++) begin
            @(negedge clk_a);
            if (!cpu_rd_ready) begin
                granted = 1'b1;
                push_host(24'd0, cyc + 1, 1'b0);
            end else begin
                @(posedge clk_a);
                #1;
            end
        end
        chk("raw_host_granted", 64'(granted), 64'd1);
        @(posedge clk_a);
        #1;
        cpu_rd_req = 1'b1;
        cpu_addr = 10'o7;
        @(negedge clk_a);
        chk("raw_cpu_ready", 64'(cpu_rd_ready), 64'd1);
        push_cpu(24'h00ABCD, cyc + 2);
        @(posedge clk_a);
        #1;
        cpu_rd_req = 1'b0;
        host_req = 1'b0;
        drain();

        // Reset one cycle after a lookup is accepted: no return, clear restarts
        cpu_rd_req = 1'b1;
        cpu_addr = 10'd3;
        @(negedge clk_a);
        chk("midreset_accept", 64'(cpu_rd_ready), 64'd1);
        @(posedge clk_a);
        #1;
        cpu_rd_req = 1'b0;
        reset = 1'b1;
        @(posedge clk_a);
        #1;
        reset = 1'b0;
        @(negedge clk_a);
        chk("midreset_no_valid", 64'(cpu_rd_valid), 64'd0);
        chk("midreset_init_done", 64'(init_done), 64'd0);
        chk("midreset_ram_idle", 64'({ram_wren, ram_rden}), 64'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_a);
            if (!(ram_wren === 1'b1 && ram_addr === 10'(i) && cpu_rd_valid === 1'b0)) bad++;
        end
        chk("midreset_clear_restart", 64'(bad), 64'd0);
        chk("rd_wr_overlap", 64'(overlap), 64'd0);
        chk("scoreboard_empty", 64'(q_cpu.size() + q_host.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
